// File: rtl/piso_stream.sv
// rtl/piso_stream.sv - parallel-in/serial-out serializer with valid/ready load and per-word bit order
// Optional even-parity bit after the data bits: define PISO_STREAM_PARITY_EN.
module piso_stream #(
    parameter int WIDTH   = 8,
    parameter int CLK_DIV = 1
) (
    input  logic             clk_in,
    input  logic             reset_n_in,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    output logic             ready_out,
    input  logic             lsb_first_in,
    output logic             serial_out,
    output logic             frame_out,
    output logic             done_out
);

`ifdef PISO_STREAM_PARITY_EN
    localparam int NBITS = WIDTH + 1;
`else
    localparam int NBITS = WIDTH;
`endif
    localparam int BIT_W = $clog2(WIDTH + 1);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(NBITS - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q;
    logic             lsb_q;
    logic [BIT_W-1:0] bit_cnt;
    logic [DIV_W-1:0] div_cnt;
    logic             last_period;
    logic             handshake;
    logic             next_bit;
`ifdef PISO_STREAM_PARITY_EN
    logic             parity_q;
`endif

    always_comb begin
        last_period = 1'b0;
        ready_out   = 1'b0;
        state_d     = state_q;
        next_bit    = lsb_q ? shift_q[0] : shift_q[WIDTH-1];
`ifdef PISO_STREAM_PARITY_EN
        if (bit_cnt == BIT_W'(WIDTH - 1))
            next_bit = parity_q;
`endif
        last_period = (state_q == SHIFT) && (bit_cnt == BIT_LAST) && (div_cnt == DIV_LAST);
        ready_out   = (state_q == IDLE) || last_period;
        handshake   = valid_in && ready_out;
        if (handshake)
            state_d = SHIFT;
        else if (last_period)
            state_d = IDLE;
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            lsb_q      <= 1'b0;
            bit_cnt    <= '0;
            div_cnt    <= '0;
            serial_out <= 1'b0;
            frame_out  <= 1'b0;
            done_out   <= 1'b0;
`ifdef PISO_STREAM_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            done_out <= last_period;
            if (handshake) begin
                // First bit goes straight to the output; the register keeps the rest.
                serial_out <= lsb_first_in ? data_in[0] : data_in[WIDTH-1];
                shift_q    <= lsb_first_in ? (data_in >> 1) : (data_in << 1);
                lsb_q      <= lsb_first_in;
                bit_cnt    <= '0;
                div_cnt    <= '0;
                frame_out  <= 1'b1;
`ifdef PISO_STREAM_PARITY_EN
                parity_q   <= ^data_in;
`endif
            end else if (last_period) begin
                serial_out <= 1'b0;
                frame_out  <= 1'b0;
                bit_cnt    <= '0;
                div_cnt    <= '0;
            end else if (state_q == SHIFT) begin
                if (div_cnt == DIV_LAST) begin
                    div_cnt    <= '0;
                    bit_cnt    <= bit_cnt + BIT_W'(1);
                    serial_out <= next_bit;
                    shift_q    <= lsb_q ? (shift_q >> 1) : (shift_q << 1);
                end else begin
                    div_cnt <= div_cnt + DIV_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_piso_stream.sv
// tb/tb_piso_stream.sv - directed self-checking bench for piso_stream (CLK_DIV=1 and CLK_DIV=3 instances)
module tb_piso_stream;

`ifdef PISO_STREAM_PARITY_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif

    logic       clk_in = 1'b0;
    logic       reset_n_in = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       lsb_first_in = 1'b0;
    logic       valid1 = 1'b0, valid3 = 1'b0;
    logic       ready1, serial1, frame1, done1;
    logic       ready3, serial3, frame3, done3;

    int checks = 0;
    int errors = 0;

    always #5 clk_in = ~clk_in;

    piso_stream #(.WIDTH(8), .CLK_DIV(1)) u_div1 (
        .clk_in(clk_in), .reset_n_in(reset_n_in), .data_in(data_in), .valid_in(valid1),
        .ready_out(ready1), .lsb_first_in(lsb_first_in), .serial_out(serial1),
        .frame_out(frame1), .done_out(done1)
    );

    piso_stream #(.WIDTH(8), .CLK_DIV(3)) u_div3 (
        .clk_in(clk_in), .reset_n_in(reset_n_in), .data_in(data_in), .valid_in(valid3),
        .ready_out(ready3), .lsb_first_in(lsb_first_in), .serial_out(serial3),
        .frame_out(frame3), .done_out(done3)
    );

    task automatic check(input string tag, input logic actual, input logic expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", tag, actual, expected, $time);
        end
    endtask

    // Bit i of a frame: 8 data bits in wire order (given MSB-leftmost), then parity.
    function automatic logic exp_bit(input logic [7:0] wire_bits, input logic par, input int i);
        return (i < 8) ? wire_bits[7 - i] : par;
    endfunction

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic run_word(input string tag, input logic [7:0] d, input logic lsb,
                            input logic [7:0] wire_bits, input logic par);
        data_in      = d;
        lsb_first_in = lsb;
        valid1       = 1'b1;
        tick();
        valid1  = 1'b0;
        data_in = ~d;
        for (int i = 0; i < NB; i++) begin
            check({tag, "_bit"}, serial1, exp_bit(wire_bits, par, i));
            check({tag, "_frame"}, frame1, 1'b1);
            check({tag, "_ready"}, ready1, i == NB - 1);
            check({tag, "_done_mid"}, done1, 1'b0);
            if (i != NB - 1) tick();
        end
        tick();
        check({tag, "_done"}, done1, 1'b1);
        check({tag, "_frame_end"}, frame1, 1'b0);
        check({tag, "_serial_end"}, serial1, 1'b0);
        check({tag, "_ready_idle"}, ready1, 1'b1);
    endtask

    initial begin
        #12;
        check("rst_serial", serial1, 1'b0);
        check("rst_frame", frame1, 1'b0);
        check("rst_done", done1, 1'b0);
        check("rst_ready", ready1, 1'b1);
        check("rst_ready3", ready3, 1'b1);
        reset_n_in = 1'b1;
        tick();

        run_word("a5_msb", 8'hA5, 1'b0, 8'b10100101, 1'b0);
        run_word("03_lsb", 8'h03, 1'b1, 8'b11000000, 1'b0);
        run_word("03_msb", 8'h03, 1'b0, 8'b00000011, 1'b0);
        run_word("07_msb", 8'h07, 1'b0, 8'b00000111, 1'b1);

        // Slow instance: each bit held three cycles.
        data_in = 8'h81; lsb_first_in = 1'b0; valid3 = 1'b1;
        tick();
        valid3 = 1'b0;
        for (int i = 0; i < NB * 3; i++) begin
            check("div3_bit", serial3, exp_bit(8'b10000001, 1'b0, i / 3));
            check("div3_frame", frame3, 1'b1);
            check("div3_ready", ready3, i == NB * 3 - 1);
            if (i != NB * 3 - 1) tick();
        end
        tick();
        check("div3_done", done3, 1'b1);
        check("div3_frame_end", frame3, 1'b0);

        // Back-to-back words with valid held high.
        data_in = 8'h0F; lsb_first_in = 1'b0; valid1 = 1'b1;
        tick();
        data_in = 8'hF0;
        for (int i = 0; i < 2 * NB; i++) begin
            check("b2b_bit", serial1, exp_bit((i < NB) ? 8'h0F : 8'hF0, 1'b0, i % NB));
            check("b2b_frame", frame1, 1'b1);
            check("b2b_done", done1, i == NB);
            check("b2b_ready", ready1, (i == NB - 1) || (i == 2 * NB - 1));
            if (i == NB) valid1 = 1'b0;
            if (i != 2 * NB - 1) tick();
        end
        tick();
        check("b2b_done_end", done1, 1'b1);
        check("b2b_frame_end", frame1, 1'b0);

        // Asynchronous reset in the middle of a word.
        data_in = 8'hFF; valid1 = 1'b1;
        tick();
        valid1 = 1'b0;
        tick();
        tick();
        check("pre_rst_frame", frame1, 1'b1);
        check("pre_rst_serial", serial1, 1'b1);
        #2 reset_n_in = 1'b0;
        #1;
        check("async_rst_serial", serial1, 1'b0);
        check("async_rst_frame", frame1, 1'b0);
        check("async_rst_done", done1, 1'b0);
        check("async_rst_ready", ready1, 1'b1);
        valid1 = 1'b1;
        tick();
        check("rst_hs_ignored", frame1, 1'b0);
        valid1 = 1'b0;
        reset_n_in = 1'b1;
        run_word("55_after_rst", 8'h55, 1'b0, 8'b01010101, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/piso_stream.md
Name: piso_stream

Overview:
Parametrised parallel-in/serial-out serializer with a valid/ready load handshake, configurable bit period, and per-word bit order. It emits a frame strobe and a word-done pulse. It sits between register/command logic and serial links to stepper drivers. Back-to-back words stream gaplessly when the next word is offered in time.

Parameters:
WIDTH, 8, data word width in bits; legal range >= 2.
CLK_DIV, 1, clk_in cycles each bit is held on serial_out; legal range >= 1.

Ports:
clk_in  input  1  system clock; all logic on rising edge
reset_n_in  input  1  asynchronous active-low reset
data_in  input  WIDTH  word to serialize; sampled only on handshake
valid_in  input  1  data_in valid
ready_out  output  1  block accepts a word this cycle; combinational from state/counters
lsb_first_in  input  1  bit order for the offered word: 0 = MSB first, 1 = LSB first; sampled on handshake
serial_out  output  1  registered serial data
frame_out  output  1  registered; high while any bit period is being driven
done_out  output  1  registered one-cycle pulse per completed word

Behaviour:
- Reset is asynchronous on reset_n_in low and applies immediately, including mid-word:
  - state goes to IDLE;
  - serial_out = 0, frame_out = 0, done_out = 0;
  - shift register, bit counter and divider counter are cleared;
  - ready_out reads 1 (IDLE), but handshakes are ignored while reset is asserted.
- Handshake: a word is accepted on a rising edge where valid_in && ready_out.
- States:
  - IDLE: ready_out = 1; serial_out = 0; frame_out = 0. On handshake: latch data_in and lsb_first_in, go to SHIFT.
  - SHIFT: ready_out = 1 only in the final clk_in cycle of the final bit period (bit_cnt == last, div_cnt == CLK_DIV-1), else 0.
- Latency: the first bit appears on serial_out, with frame_out = 1, in the cycle immediately after the handshake edge.
- Bit timing:
  - each bit is held exactly CLK_DIV cycles;
  - a word occupies WIDTH*CLK_DIV cycles.
- Bit order:
  - MSB-first sends data[WIDTH-1] down to data[0];
  - LSB-first sends data[0] up to data[WIDTH-1].
- End of final bit period, with handshake in the same cycle:
  - new word loaded; its first bit is driven next cycle;
  - frame_out stays 1 (no gap);
  - done_out pulses 1 for the completed word;
  - state stays SHIFT.
- End of final bit period, without handshake:
  - next cycle: state IDLE, frame_out = 0, serial_out = 0, done_out = 1 for one cycle.
- valid_in while ready_out = 0: ignored; the upstream must hold valid/data until ready. data_in changes after the handshake do not affect the word in flight.
- Counter widths:
  - bit counter is $clog2(WIDTH+1) bits;
  - divider counter is max(1, $clog2(CLK_DIV)) bits;
  - both wrap to 0 at word or bit boundaries with no overflow.
- CLK_DIV = 1: div_cnt is constantly 0; ready_out is high during every final-bit cycle.

Optional Feature:
Macro PISO_STREAM_PARITY_EN.
- Defined:
  - one even-parity bit (XOR of all WIDTH data bits) is appended after the data bits, independent of bit order;
  - the word becomes (WIDTH+1)*CLK_DIV cycles;
  - the ready window and done_out timing move to the end of the parity bit period.
- Undefined: no parity bit; timing exactly as above.

Test Plan:
1. WIDTH=8, CLK_DIV=1, MSB-first, data 0xA5 single handshake -> serial_out 1,0,1,0,0,1,0,1 on cycles 1–8 after handshake; frame_out high cycles 1–8; done_out = 1 on cycle 9 with frame_out = 0.
2. WIDTH=8, CLK_DIV=1, lsb_first_in = 1, data 0x03 -> serial_out 1,1,0,0,0,0,0,0; then the next word 0x03 sent MSB-first -> 0,0,0,0,0,0,1,1 (per-word order latching).
3. WIDTH=8, CLK_DIV=3, data 0x81 MSB-first -> 1 for 3 cycles, 0 for 18 cycles, 1 for 3 cycles; frame_out high exactly 24 cycles; ready_out high only in IDLE and cycle 24.
4. valid_in held high with 0x0F then 0xF0, CLK_DIV=1, MSB-first -> 16 contiguous bits 0000111111110000; frame_out high 16 cycles with no gap; done_out pulses at cycles 9 and 17.
5. Reset asserted asynchronously after 3 bits of 0xFF -> serial_out, frame_out and done_out drop to 0 without a clock edge; after release, a new 0x55 is serialized from its first bit 0,1,0,1,0,1,0,1.
6. With PISO_STREAM_PARITY_EN, CLK_DIV=1: 0x07 -> 9th bit 1 and done_out on cycle 10; 0x03 -> 9th bit 0.
